reg_rename_file: RTL and testbench
==================================

Name: reg_rename_file

Overview:
- Architectural register file plus rename-status table for the RISC-V out-of-order core.
- Consumer end of the reorder-buffer commit interface: writes committed results to x1..x31 and clears each register's busy tag when its youngest producer commits.
- Also the producer end of the dispatch interface: on dispatch it marks the destination register busy, tagged with the instruction PC, and returns source-operand value or tag to the decoder.
- A reorder-buffer exception (mispredict flush) clears every pending tag.

Parameters:
- RegNum, 32, number of architectural registers; x0 is hardwired to zero.
- RdLength, 4, MSB index of a register-number field (5-bit index).

Ports:
- clk  input  1  clock; every state change happens on the rising edge
- rst  input  1  reset, synchronous, active-high
- is_empty_from_dc  input  1  low = an instruction is dispatched this cycle
- rd_from_dc  input  RdLength+1  destination register of the dispatched instruction
- pc_from_dc  input  `PcLength+1  PC of the dispatched instruction; used as its rename tag
- rs1_from_dc  input  RdLength+1  source register 1 index
- rs2_from_dc  input  RdLength+1  source register 2 index
- is_commit_from_rob  input  1  commit strobe
- commit_rd_from_rob  input  RdLength+1  committed destination register
- commit_pc_from_rob  input  `PcLength+1  committed instruction tag
- commit_data_from_rob  input  `DataLength+1  committed result
- is_exception_from_rob  input  1  flush
- data1_to_dc, data2_to_dc  output  `DataLength+1  operand values
- tag1_to_dc, tag2_to_dc  output  `PcLength+1  producer tags; 0 when the source is not busy
- is_busy1_to_dc, is_busy2_to_dc  output  1  operand still pending

Behaviour:
- State per register: data[i], busy[i], tag[i].
- Reset (rst=1 at a clock edge):
  - all data, busy and tag are cleared to 0;
  - outputs therefore read 0, not busy, tag 0;
  - reset overrides commit, dispatch and exception in the same cycle.
- x0: never written and never busy; reads always give data 0, busy 0, tag 0.
- Dispatch (is_empty_from_dc=0, rd≠0, no exception): busy[rd]←1, tag[rd]←pc_from_dc. Dispatch with rd=0 has no effect.
- Commit (is_commit_from_rob=1, commit_rd≠0):
  - data[commit_rd] is always written;
  - busy[commit_rd]←0 and tag←0 only when busy=1 and tag[commit_rd]==commit_pc;
  - on a tag mismatch (a younger producer is in flight) busy and tag are unchanged.
- Commit and dispatch to the same rd in one cycle: data is written from the commit; busy=1 and tag=pc_from_dc from the dispatch (dispatch wins).
- Exception (is_exception_from_rob=1):
  - the commit presented in the same cycle is still written, since the ROB raises exception together with the mispredicting commit;
  - every busy is cleared and every tag set to 0;
  - dispatch in that cycle is ignored.
- Read ports: combinational from current state with zero latency.
  - The dispatched instruction's own rd does not affect its own sources in the same cycle; rs1==rd reads the old mapping.
  - Read ordering is therefore state first, then bypass (see Optional Feature).
- No handshake back-pressure: every strobe is accepted in the cycle it is presented.

Optional Feature:
- Macro REG_COMMIT_BYPASS_EN.
- Defined: if a source is busy, is_commit_from_rob=1, commit_rd==source index and commit_pc==tag[source], the port returns commit_data_from_rob with busy 0 and tag 0 in that same cycle.
- Undefined: the port returns registered state only. The same-cycle commit shows as busy with the old tag; the reservation station picks the value up from its own commit broadcast.

Decomposition:
- parameters.v (shared): `DataLength, `PcLength, `Zero, `True, `False; add a `RegZero index constant.
- One natural sub-module, reg_read_port, instantiated twice. It takes an index plus the state arrays and commit bus, and produces data/tag/busy, with the bypass logic under the macro.

Test Plan:
- Reset → reads of x5 and x31 return data 0, busy 0, tag 0; a commit in the reset cycle is discarded.
- Dispatch rd=5, pc=0x100, then commit rd=5, pc=0x100, data=0xDEADBEEF → next cycle rs1=5 reads 0xDEADBEEF, busy 0.
- Dispatch rd=7 pc=0x200, dispatch rd=7 pc=0x204, commit rd=7 pc=0x200 data=1 → data[7]=1 but busy=1, tag=0x204; commit pc=0x204 data=2 → busy 0, data 2.
- Dispatch rd=3 pc=0x300; in a later cycle exception plus commit rd=4 data=9, with a dispatch rd=6 pc=0x308 in the same cycle → x3 not busy, x4=9, x6 not busy.
- Dispatch rd=0 pc=0x400 and commit rd=0 data=5 → x0 reads 0, not busy.
- With REG_COMMIT_BYPASS_EN, x9 busy with tag 0x500 and commit rd=9 pc=0x500 data=0x77 while rs2=9 → same cycle data2=0x77, busy2 0. Without the macro → busy2 1, tag2 0x500.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
// Shared constants for the architectural register file / rename-status table.
// Optional same-cycle commit bypass on the read ports: REG_COMMIT_BYPASS_EN.
package reg_rename_file_pkg;
  localparam int DataLength = 31;   // MSB of a data word
  localparam int PcLength   = 31;   // MSB of a PC / rename tag
  localparam int RegNumDef  = 32;
  localparam int RdLengthDef = 4;
  localparam int RegZero    = 0;    // x0, hardwired to zero

  typedef logic [DataLength:0] data_t;
  typedef logic [PcLength:0]   tag_t;
endpackage

// File: rtl/reg_read_port.sv
// One combinational source-operand read port: value, producer tag, busy flag.
// With REG_COMMIT_BYPASS_EN the commit being presented this cycle resolves a
// pending operand immediately; otherwise only registered state is visible.
import reg_rename_file_pkg::*;

module reg_read_port #(
  parameter int RegNum   = RegNumDef,
  parameter int RdLength = RdLengthDef
) (
  input  logic [RdLength:0]             idx_i,
  input  data_t [RegNum-1:0]            data_i,
  input  tag_t  [RegNum-1:0]            tag_i,
  input  logic  [RegNum-1:0]            busy_i,
`ifdef REG_COMMIT_BYPASS_EN
  input  logic                          commit_i,
  input  logic [RdLength:0]             commit_rd_i,
  input  tag_t                          commit_pc_i,
  input  data_t                         commit_data_i,
`endif
  output data_t                         data_o,
  output tag_t                          tag_o,
  output logic                          busy_o
);

  // State first; x0 is forced to zero/idle regardless of array contents.
  always_comb begin
    data_o = '0;
    tag_o  = '0;
    busy_o = 1'b0;
    if (idx_i != RdLength'(RegZero)) begin
      data_o = data_i[idx_i];
      tag_o  = tag_i[idx_i];
      busy_o = busy_i[idx_i];
`ifdef REG_COMMIT_BYPASS_EN
      // Youngest producer committing right now: hand its result straight over.
      if (busy_i[idx_i] && commit_i && (commit_rd_i == idx_i) &&
          (commit_pc_i == tag_i[idx_i])) begin
        data_o = commit_data_i;
        tag_o  = '0;
        busy_o = 1'b0;
      end
`endif
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file plus rename-status table. Commits from the ROB
// write data and retire busy tags; dispatch marks destinations busy tagged
// with the PC; an ROB exception flushes every pending tag.
// Optional feature macro: REG_COMMIT_BYPASS_EN (commit-to-read bypass).
import reg_rename_file_pkg::*;

module reg_rename_file #(
  parameter int RegNum   = RegNumDef,
  parameter int RdLength = RdLengthDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_empty_from_dc,
  input  logic [RdLength:0] rd_from_dc,
  input  tag_t              pc_from_dc,
  input  logic [RdLength:0] rs1_from_dc,
  input  logic [RdLength:0] rs2_from_dc,
  input  logic              is_commit_from_rob,
  input  logic [RdLength:0] commit_rd_from_rob,
  input  tag_t              commit_pc_from_rob,
  input  data_t             commit_data_from_rob,
  input  logic              is_exception_from_rob,
  output data_t             data1_to_dc,
  output data_t             data2_to_dc,
  output tag_t              tag1_to_dc,
  output tag_t              tag2_to_dc,
  output logic              is_busy1_to_dc,
  output logic              is_busy2_to_dc
);

  data_t [RegNum-1:0] data_q, data_d;
  tag_t  [RegNum-1:0] tag_q,  tag_d;
  logic  [RegNum-1:0] busy_q, busy_d;

  logic commit_en, dispatch_en;
  assign commit_en   = is_commit_from_rob && (commit_rd_from_rob != RdLength'(RegZero));
  assign dispatch_en = !is_empty_from_dc && (rd_from_dc != RdLength'(RegZero));

  // Next state: commit first, then flush or dispatch (dispatch overrides a
  // same-register commit for busy/tag; data always comes from the commit).
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (commit_en) begin
      data_d[commit_rd_from_rob] = commit_data_from_rob;
      if (busy_q[commit_rd_from_rob] &&
          (tag_q[commit_rd_from_rob] == commit_pc_from_rob)) begin
        busy_d[commit_rd_from_rob] = 1'b0;
        tag_d[commit_rd_from_rob]  = '0;
      end
    end
    if (is_exception_from_rob) begin
      busy_d = '0;
      tag_d  = '0;
    end else if (dispatch_en) begin
      busy_d[rd_from_dc] = 1'b1;
      tag_d[rd_from_dc]  = pc_from_dc;
    end
  end

  // State registers with synchronous reset overriding all strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      tag_q  <= '0;
      busy_q <= '0;
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  reg_read_port #(.RegNum(RegNum), .RdLength(RdLength)) u_rd1 (
    .idx_i         (rs1_from_dc),
    .data_i        (data_q),
    .tag_i         (tag_q),
    .busy_i        (busy_q),
`ifdef REG_COMMIT_BYPASS_EN
    .commit_i      (is_commit_from_rob),
    .commit_rd_i   (commit_rd_from_rob),
    .commit_pc_i   (commit_pc_from_rob),
    .commit_data_i (commit_data_from_rob),
`endif
    .data_o        (data1_to_dc),
    .tag_o         (tag1_to_dc),
    .busy_o        (is_busy1_to_dc)
  );

  reg_read_port #(.RegNum(RegNum), .RdLength(RdLength)) u_rd2 (
    .idx_i         (rs2_from_dc),
    .data_i        (data_q),
    .tag_i         (tag_q),
    .busy_i        (busy_q),
`ifdef REG_COMMIT_BYPASS_EN
    .commit_i      (is_commit_from_rob),
    .commit_rd_i   (commit_rd_from_rob),
    .commit_pc_i   (commit_pc_from_rob),
    .commit_data_i (commit_data_from_rob),
`endif
    .data_o        (data2_to_dc),
    .tag_o         (tag2_to_dc),
    .busy_o        (is_busy2_to_dc)
  );

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file with hand-computed expectations.
module tb_reg_rename_file;
  import reg_rename_file_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_empty_from_dc;
  logic [4:0]  rd_from_dc, rs1_from_dc, rs2_from_dc, commit_rd_from_rob;
  tag_t        pc_from_dc, commit_pc_from_rob;
  data_t       commit_data_from_rob;
  logic        is_commit_from_rob, is_exception_from_rob;
  data_t       data1_to_dc, data2_to_dc;
  tag_t        tag1_to_dc, tag2_to_dc;
  logic        is_busy1_to_dc, is_busy2_to_dc;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  reg_rename_file dut (
    .clk                  (clk),
    .rst                  (rst),
    .is_empty_from_dc     (is_empty_from_dc),
    .rd_from_dc           (rd_from_dc),
    .pc_from_dc           (pc_from_dc),
    .rs1_from_dc          (rs1_from_dc),
    .rs2_from_dc          (rs2_from_dc),
    .is_commit_from_rob   (is_commit_from_rob),
    .commit_rd_from_rob   (commit_rd_from_rob),
    .commit_pc_from_rob   (commit_pc_from_rob),
    .commit_data_from_rob (commit_data_from_rob),
    .is_exception_from_rob(is_exception_from_rob),
    .data1_to_dc          (data1_to_dc),
    .data2_to_dc          (data2_to_dc),
    .tag1_to_dc           (tag1_to_dc),
    .tag2_to_dc           (tag2_to_dc),
    .is_busy1_to_dc       (is_busy1_to_dc),
    .is_busy2_to_dc       (is_busy2_to_dc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Clear all strobes.
  task automatic idle();
    is_empty_from_dc      = 1'b1;
    rd_from_dc            = '0;
    pc_from_dc            = '0;
    is_commit_from_rob    = 1'b0;
    commit_rd_from_rob    = '0;
    commit_pc_from_rob    = '0;
    commit_data_from_rob  = '0;
    is_exception_from_rob = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic disp(input logic [4:0] rd, input logic [31:0] pc);
    is_empty_from_dc = 1'b0; rd_from_dc = rd; pc_from_dc = pc;
  endtask

  task automatic cmt(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] d);
    is_commit_from_rob = 1'b1; commit_rd_from_rob = rd;
    commit_pc_from_rob = pc; commit_data_from_rob = d;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    idle();
    rs1_from_dc = 5'd5; rs2_from_dc = 5'd31;
    rst = 1'b1;
    @(posedge clk); #1;
    // reset cycle with a commit that must be discarded
    cmt(5'd5, 32'h0, 32'h55);
    step();
    rst = 1'b0;
    settle();
    chk("rst_data1", data1_to_dc, 0);
    chk("rst_busy1", is_busy1_to_dc, 0);
    chk("rst_tag1",  tag1_to_dc, 0);
    chk("rst_data2", data2_to_dc, 0);
    chk("rst_busy2", is_busy2_to_dc, 0);
    chk("rst_tag2",  tag2_to_dc, 0);

    // dispatch rd=5, own source reads the old mapping
    disp(5'd5, 32'h100);
    settle();
    chk("disp_self_busy", is_busy1_to_dc, 0);
    step(); settle();
    chk("x5_busy", is_busy1_to_dc, 1);
    chk("x5_tag",  tag1_to_dc, 32'h100);
    cmt(5'd5, 32'h100, 32'hDEADBEEF);
    settle();
`ifdef REG_COMMIT_BYPASS_EN
    chk("x5_byp_data", data1_to_dc, 32'hDEADBEEF);
    chk("x5_byp_busy", is_busy1_to_dc, 0);
`else
    chk("x5_nobyp_busy", is_busy1_to_dc, 1);
    chk("x5_nobyp_tag",  tag1_to_dc, 32'h100);
`endif
    step(); settle();
    chk("x5_cm_data", data1_to_dc, 32'hDEADBEEF);
    chk("x5_cm_busy", is_busy1_to_dc, 0);
    chk("x5_cm_tag",  tag1_to_dc, 0);

    // two producers for x7, older commits first
    rs1_from_dc = 5'd7;
    disp(5'd7, 32'h200); step();
    disp(5'd7, 32'h204); step();
    cmt(5'd7, 32'h200, 32'h1); step(); settle();
    chk("x7_old_data", data1_to_dc, 1);
    chk("x7_old_busy", is_busy1_to_dc, 1);
    chk("x7_old_tag",  tag1_to_dc, 32'h204);
    cmt(5'd7, 32'h204, 32'h2); step(); settle();
    chk("x7_new_data", data1_to_dc, 2);
    chk("x7_new_busy", is_busy1_to_dc, 0);
    chk("x7_new_tag",  tag1_to_dc, 0);

    // exception flush with simultaneous commit and ignored dispatch
    rs1_from_dc = 5'd3; rs2_from_dc = 5'd4;
    disp(5'd3, 32'h300); step(); settle();
    chk("x3_busy_pre", is_busy1_to_dc, 1);
    is_exception_from_rob = 1'b1;
    cmt(5'd4, 32'h3F0, 32'h9);
    disp(5'd6, 32'h308);
    step(); settle();
    chk("exc_x3_busy", is_busy1_to_dc, 0);
    chk("exc_x3_tag",  tag1_to_dc, 0);
    chk("exc_x4_data", data2_to_dc, 9);
    chk("exc_x4_busy", is_busy2_to_dc, 0);
    rs1_from_dc = 5'd6; settle();
    chk("exc_x6_busy", is_busy1_to_dc, 0);
    chk("exc_x6_tag",  tag1_to_dc, 0);

    // same-cycle commit and dispatch to x8: data from commit, busy from dispatch
    rs1_from_dc = 5'd8;
    disp(5'd8, 32'h600); step();
    cmt(5'd8, 32'h600, 32'hAA); disp(5'd8, 32'h610); step(); settle();
    chk("x8_data", data1_to_dc, 32'hAA);
    chk("x8_busy", is_busy1_to_dc, 1);
    chk("x8_tag",  tag1_to_dc, 32'h610);

    // x0 stays zero
    rs1_from_dc = 5'd0;
    disp(5'd0, 32'h400); cmt(5'd0, 32'h0, 32'h5); step(); settle();
    chk("x0_data", data1_to_dc, 0);
    chk("x0_busy", is_busy1_to_dc, 0);
    chk("x0_tag",  tag1_to_dc, 0);

    // bypass behaviour on port 2
    rs2_from_dc = 5'd9;
    disp(5'd9, 32'h500); step();
    cmt(5'd9, 32'h500, 32'h77); settle();
`ifdef REG_COMMIT_BYPASS_EN
    chk("x9_byp_data", data2_to_dc, 32'h77);
    chk("x9_byp_busy", is_busy2_to_dc, 0);
    chk("x9_byp_tag",  tag2_to_dc, 0);
`else
    chk("x9_nobyp_busy", is_busy2_to_dc, 1);
    chk("x9_nobyp_tag",  tag2_to_dc, 32'h500);
`endif
    step(); settle();
    chk("x9_data", data2_to_dc, 32'h77);
    chk("x9_busy", is_busy2_to_dc, 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
